// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RDRSP   = 3'd2,
        WR      = 3'd3,
        RMW_RD  = 3'd4,
        RMW_MRG = 3'd5,
        ERR     = 3'd6
    } state_e;

endpackage

// File: rtl/mem_access_unit_store_merge.sv
// Byte-store lane merge: keeps the old upper byte and inserts the new low byte.
module store_merge
    import mem_pkg::*;
(
    input  logic [7:0]        old_hi,
    input  logic [7:0]        new_byte,
    output logic [DATA_W-1:0] merged
);

    assign merged = {old_hi, new_byte};

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for the 16-bit byte-addressed data memory.
// Optional macro ALIGN_CHECK_EN: odd-address word requests are rejected with rsp_err.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wrEnable,
    output logic              mem_rdEnable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_numberOfByte,
    input  logic [DATA_W-1:0] mem_out
);

    state_e            state_r, state_nxt_s;
    logic              size_r;
    logic [7:0]        wbyte_r;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] merged_s;
    logic              accept_s, misalign_s;

    logic              ready_r, rsp_valid_r, rsp_err_r, wr_en_r, rd_en_r, nob_r;
    logic [DATA_W-1:0] rsp_rdata_r, mem_in_r;
    logic [ADDR_W-1:0] mem_addr_r;

    logic              ready_nxt_s, rsp_valid_nxt_s, rsp_err_nxt_s;
    logic              wr_nxt_s, rd_nxt_s, nob_nxt_s;
    logic [DATA_W-1:0] rsp_rdata_nxt_s, mem_in_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s;

    assign accept_s = req_valid && (state_r == IDLE);
    // The accepting cycle issues straight from the request fields; later cycles use the latched copy.
    assign addr_s   = (state_r == IDLE) ? req_addr : addr_r;

`ifdef ALIGN_CHECK_EN
    assign misalign_s = (req_size == SIZE_WORD) && req_addr[0];
`else
    assign misalign_s = 1'b0;
`endif

    store_merge u_store_merge (
        .old_hi   (mem_out[DATA_W-1:8]),
        .new_byte (wbyte_r),
        .merged   (merged_s)
    );

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s)                    state_nxt_s = IDLE;
                else if (misalign_s)              state_nxt_s = ERR;
                else if (!req_write)              state_nxt_s = RD;
                else if (req_size == SIZE_WORD)   state_nxt_s = WR;
                else                              state_nxt_s = RMW_RD;
            end
            RD:      state_nxt_s = RDRSP;
            RDRSP:   state_nxt_s = IDLE;
            WR:      state_nxt_s = IDLE;
            RMW_RD:  state_nxt_s = RMW_MRG;
            RMW_MRG: state_nxt_s = WR;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: memory strobes follow the state being entered, responses the state being left.
    always_comb begin
        wr_nxt_s        = (state_nxt_s == WR);
        rd_nxt_s        = (state_nxt_s == RD) || (state_nxt_s == RMW_RD);
        mem_addr_nxt_s  = (wr_nxt_s || rd_nxt_s) ? addr_s : {ADDR_W{1'b0}};
        ready_nxt_s     = (state_nxt_s == IDLE);
        rsp_valid_nxt_s = (state_r == RDRSP) || (state_r == WR) || (state_r == ERR);
        rsp_err_nxt_s   = (state_r == ERR);
        case (state_nxt_s)
            RD:      nob_nxt_s = req_size;
            RMW_RD:  nob_nxt_s = SIZE_WORD;
            default: nob_nxt_s = SIZE_BYTE;
        endcase
        if (!wr_nxt_s)                mem_in_nxt_s = {DATA_W{1'b0}};
        else if (state_r == RMW_MRG)  mem_in_nxt_s = merged_s;
        else                          mem_in_nxt_s = req_wdata;
        if (state_r != RDRSP)         rsp_rdata_nxt_s = rsp_rdata_r;
        else if (size_r == SIZE_WORD) rsp_rdata_nxt_s = mem_out;
        else                          rsp_rdata_nxt_s = {8'h00, mem_out[7:0]};
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            size_r      <= SIZE_BYTE;
            wbyte_r     <= 8'h00;
            addr_r      <= {ADDR_W{1'b0}};
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            wr_en_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            nob_r       <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_in_r    <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            if (accept_s) begin
                size_r  <= req_size;
                wbyte_r <= req_wdata[7:0];
                addr_r  <= req_addr;
            end
            ready_r     <= ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            wr_en_r     <= wr_nxt_s;
            rd_en_r     <= rd_nxt_s;
            nob_r       <= nob_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_in_r    <= mem_in_nxt_s;
        end
    end

    assign req_ready        = ready_r;
    assign rsp_valid        = rsp_valid_r;
    assign rsp_err          = rsp_err_r;
    assign rsp_rdata        = rsp_rdata_r;
    assign mem_wrEnable     = wr_en_r;
    assign mem_rdEnable     = rd_en_r;
    assign mem_numberOfByte = nob_r;
    assign mem_address      = mem_addr_r;
    assign mem_in           = mem_in_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 256-byte memory model (1-cycle registered read).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_size;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        mem_wrEnable, mem_rdEnable, mem_numberOfByte;
    logic [15:0] mem_address, mem_in, mem_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       mem_init;
    logic [7:0] a_lo, a_hi;

    typedef struct {
        logic        is_load;
        logic [15:0] addr;
        logic        size;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } exp_t;

    exp_t q[$];

    mem_access_unit dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wrEnable(mem_wrEnable), .mem_rdEnable(mem_rdEnable),
        .mem_address(mem_address), .mem_in(mem_in),
        .mem_numberOfByte(mem_numberOfByte), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 4)  return 8'h03;
        if (i == 33) return 8'h77;
        return i[7:0];
    endfunction

    assign a_lo = mem_address[7:0];
    assign a_hi = mem_address[7:0] + 8'd1;

    // Memory model: 16-bit writes to (addr, addr+1), registered reads.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else begin
            if (mem_wrEnable) begin
                mem[a_lo] <= mem_in[7:0];
                mem[a_hi] <= mem_in[15:8];
            end
            if (mem_rdEnable)
                mem_out <= mem_numberOfByte ? {mem[a_hi], mem[a_lo]} : {8'h00, mem[a_lo]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: counts memory strobes per transaction and pops the scoreboard on each response.
    initial begin
        int nrd, nwr;
        logic [15:0] rd_addr, wr_addr;
        logic rd_nob;
        exp_t e;
        nrd = 0; nwr = 0; rd_addr = 16'h0000; wr_addr = 16'h0000; rd_nob = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                nrd = 0;
                nwr = 0;
            end else begin
                chk("wr_rd_exclusive", {31'd0, mem_wrEnable & mem_rdEnable}, 32'd0);
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_latency", cyc - e.acc, e.lat);
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        if (e.is_load && !e.err) chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                        chk("rd_count", nrd, e.nrd);
                        chk("wr_count", nwr, e.nwr);
                        if (e.nrd > 0) begin
                            chk("rd_addr", {16'd0, rd_addr}, {16'd0, e.addr});
                            chk("rd_size", {31'd0, rd_nob}, {31'd0, (e.is_load ? e.size : 1'b1)});
                        end
                        if (e.nwr > 0) chk("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
                    end
                    nrd = 0;
                    nwr = 0;
                end
                if (mem_rdEnable) begin
                    nrd++;
                    rd_addr = mem_address;
                    rd_nob = mem_numberOfByte;
                end
                if (mem_wrEnable) begin
                    nwr++;
                    wr_addr = mem_address;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic sz, input logic [15:0] a, input logic [15:0] wd);
        int t;
        exp_t e;
        logic [7:0] lo, hi;
        logic mis;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            chk("ready_wait", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_write = wr; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        e.acc = cyc;
        req_valid = 1'b0;
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
        lo = a[7:0];
        hi = lo + 8'd1;
`ifdef ALIGN_CHECK_EN
        mis = sz && a[0];
`else
        mis = 1'b0;
`endif
        e.is_load = !wr; e.addr = a; e.size = sz; e.err = 1'b0; e.rdata = 16'h0000;
        if (mis) begin
            e.err = 1'b1; e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!wr) begin
            e.lat = 2; e.nrd = 1; e.nwr = 0;
            e.rdata = sz ? {ref_mem[hi], ref_mem[lo]} : {8'h00, ref_mem[lo]};
        end else if (sz) begin
            e.lat = 1; e.nrd = 0; e.nwr = 1;
            ref_mem[lo] = wd[7:0];
            ref_mem[hi] = wd[15:8];
        end else begin
            e.lat = 3; e.nrd = 1; e.nwr = 1;
            ref_mem[lo] = wd[7:0];
        end
        q.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; mem_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_mem_ctl", {29'd0, mem_wrEnable, mem_rdEnable, mem_numberOfByte}, 32'd0);
        chk("reset_mem_bus", {mem_address, mem_in}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 1'b1, 16'h0002, 16'h0000);
        issue(1'b0, 1'b0, 16'h0004, 16'h0000);
        issue(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        issue(1'b1, 1'b0, 16'h0020, 16'h005A);
        issue(1'b0, 1'b1, 16'h0003, 16'h0000);
        issue(1'b0, 1'b1, 16'h0020, 16'h0000);
        issue(1'b0, 1'b1, 16'h0010, 16'h0000);
        issue(1'b1, 1'b1, 16'hFFFF, 16'h1234);
        issue(1'b1, 1'b0, 16'hFFFF, 16'h00C3);
        issue(1'b0, 1'b1, 16'hFFFE, 16'h0000);
        drain();

        // Reset while a byte store sits in the merge cycle must not leave a write behind.
        req_write = 1'b1; req_size = 1'b0; req_addr = 16'h0020; req_wdata = 16'h00A5;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_ctl", {29'd0, mem_wrEnable, mem_rdEnable, mem_numberOfByte}, 32'd0);
        chk("rst_mid_mem_bus", {mem_address, mem_in}, 32'd0);
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;

        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            a = (n % 10 == 0) ? 16'(16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom_range(0, 65535));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        drain();
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 256; i++)
            chk("mem_byte", {16'(i), 8'h00, mem[i]}, {16'(i), 8'h00, ref_mem[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
